conway_state_reader: RTL and testbench
======================================

Name: conway_state_reader

Overview:
Readout and stepping controller for the Conway grid core. It snapshots the grid's current-state vector and streams it out one row per valid/ready handshake. After each frame drains it can issue a single-cycle clock-enable pulse to advance the core by exactly one generation. It sits between the grid core (whose CURRENT_STATE drives STATE_IN and whose CLK_EN is driven by CLK_EN_OUT) and any row-oriented consumer such as a display driver or a host link.

Parameters:
ROWS, 8, number of grid rows (frame length in beats)
COLS, 8, number of grid columns (row beat width)
GEN_WIDTH, 16, width of the generation counter

Ports:
CLK  input  1  system clock
RESET  input  1  synchronous active-high reset
STATE_IN  input  ROWS*COLS  current grid state; row r is bits [r*COLS +: COLS]
START  input  1  pulse: read one frame (ignored unless IDLE)
RUN_EN  input  1  level: free-run capture/send/advance loop
ADVANCE_EN  input  1  level: step the core after a frame drains
GEN_CLEAR  input  1  pulse: zero the generation counter
ROW_DATA  output  COLS  current row beat
ROW_IDX  output  $clog2(ROWS)  index of the current row
ROW_VALID  output  1  beat valid
ROW_READY  input  1  consumer accepts the beat
ROW_LAST  output  1  high with the final row of a frame
LIVE_COUNT  output  $clog2(ROWS*COLS+1)  live cells in the snapshot
FRAME_GEN  output  GEN_WIDTH  generation number of the frame being sent
CLK_EN_OUT  output  1  one-cycle advance pulse to the core
BUSY  output  1  high whenever the state is not IDLE

Behaviour:
- One clock domain; the reset is synchronous and active-high. Clock port CLK, reset port RESET.
- On reset, all outputs are 0, the state is IDLE, the generation counter is 0 and the snapshot is 0.
- A reset asserted mid-frame aborts the frame. ROW_VALID and CLK_EN_OUT are 0 from the next cycle, and no partial advance occurs.
- States and transitions:
  - IDLE -> CAPTURE when START or RUN_EN is high. START arriving while not IDLE is dropped (not queued).
  - CAPTURE (1 cycle):
    - Register STATE_IN into the snapshot.
    - Register LIVE_COUNT as the population count of STATE_IN.
    - Register FRAME_GEN from the generation counter.
    - Set ROW_IDX to 0, then go to SEND.
  - SEND:
    - ROW_VALID is 1.
    - ROW_DATA is the snapshot row at ROW_IDX.
    - ROW_LAST is 1 when ROW_IDX equals ROWS-1.
    - ROW_DATA, ROW_IDX and ROW_LAST are held stable until ROW_VALID and ROW_READY are both high at a clock edge.
    - On a handshake that is not the last row, ROW_IDX increments.
    - On the last-row handshake, go to ADVANCE if ADVANCE_EN is 1, otherwise to IDLE. ROW_VALID drops the next cycle.
  - ADVANCE (1 cycle): CLK_EN_OUT is 1 and the generation counter increments, then go to SETTLE.
  - SETTLE (1 cycle): gives the core time to present the new STATE_IN. Then go to CAPTURE if RUN_EN is 1, otherwise to IDLE.
- STATE_IN changes during SEND have no effect on ROW_DATA; the snapshot isolates the frame.
- Latency and throughput:
  - START sampled at edge N gives CAPTURE in cycle N+1 and the first ROW_VALID in cycle N+2.
  - With ROW_READY held high, a frame takes exactly ROWS SEND cycles.
  - Free-run period is ROWS+3 cycles per generation (CAPTURE + ROWS + ADVANCE + SETTLE).
- Generation counter:
  - Wraps from 2^GEN_WIDTH-1 to 0.
  - GEN_CLEAR has priority over the increment when both occur in the same cycle.
  - GEN_CLEAR does not alter FRAME_GEN of a frame already captured.
- Dropping RUN_EN mid-frame finishes the current frame and its advance (if ADVANCE_EN), then returns to IDLE.
- ADVANCE_EN is sampled only at the last-row handshake.
- CLK_EN_OUT is registered and glitch-free. The integrator must ensure the core's clock gating samples it safely.

Decomposition:
- Shared package conway_pkg holds:
  - the state enum reader_state_t (IDLE, CAPTURE, SEND, ADVANCE, SETTLE);
  - the default ROWS/COLS constants;
  - a row-slice helper function.
- One sub-module: popcount_tree (parameterised width). It computes LIVE_COUNT and is combinational, registered at CAPTURE.

Test Plan:
- Reset, then START with STATE_IN=64'h0000_0000_0000_00FF and ROW_READY=1 -> 8 beats; ROW_DATA=8'hFF at ROW_IDX 0, 0 for the rest; ROW_LAST only at index 7; LIVE_COUNT=8; CLK_EN_OUT never high with ADVANCE_EN=0.
- Same frame, ROW_READY toggling 1-0-1 -> ROW_DATA and ROW_IDX hold during the stalls; still 8 accepted beats; STATE_IN changed mid-frame to all-ones is not reflected in the output.
- RUN_EN=1, ADVANCE_EN=1, ROW_READY=1 -> CLK_EN_OUT pulses exactly once every 11 cycles; FRAME_GEN reads 0,1,2,...
- Generation counter preset near wrap (GEN_WIDTH=4, 15 advances) -> FRAME_GEN goes 15 then 0; GEN_CLEAR in the same cycle as an ADVANCE -> counter is 0.
- RESET asserted during SEND at beat 3 -> the next cycle has ROW_VALID=0, BUSY=0, counter 0, and no CLK_EN_OUT pulse.
- START pulsed while BUSY -> ignored; exactly one frame is emitted; STATE_IN all-ones gives LIVE_COUNT=64.

Source files
------------

// File: rtl/conway_pkg.sv
// Shared types and helpers for the Conway grid readout path.
package conway_pkg;

  localparam int unsigned DEFAULT_ROWS = 8;
  localparam int unsigned DEFAULT_COLS = 8;
  localparam int unsigned MAX_COLS     = 64;
  localparam int unsigned MAX_GRID     = 1024;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SEND,
    ADVANCE,
    SETTLE
  } reader_state_t;

  // Row r of a flattened grid is bits [r*cols +: cols]; result is zero-padded to MAX_COLS.
  function automatic logic [MAX_COLS-1:0] row_slice(input logic [MAX_GRID-1:0] grid,
                                                    input int unsigned       row,
                                                    input int unsigned       cols);
    logic [MAX_GRID-1:0] shifted;
    logic [MAX_COLS-1:0] mask;
    shifted = grid >> (row * cols);
    mask    = {MAX_COLS{1'b1}} >> (MAX_COLS - cols);
    return MAX_COLS'(shifted) & mask;
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// Combinational population count of a bit vector.
module popcount_tree #(
  parameter  int unsigned WIDTH = 64,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_bits,
  output logic [CNT_W-1:0] o_count_c
);

  always_comb begin
    o_count_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_count_c = o_count_c + CNT_W'(i_bits[i]);
    end
  end

endmodule

// File: rtl/conway_state_reader.sv
// Snapshots the Conway grid state, streams it row by row over valid/ready,
// and optionally pulses the core clock enable to step one generation.
module conway_state_reader
  import conway_pkg::*;
#(
  parameter  int unsigned ROWS      = DEFAULT_ROWS,
  parameter  int unsigned COLS      = DEFAULT_COLS,
  parameter  int unsigned GEN_WIDTH = 16,
  localparam int unsigned GRID_W    = ROWS * COLS,
  localparam int unsigned IDX_W     = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned CNT_W     = $clog2(ROWS * COLS + 1)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [GRID_W-1:0]    STATE_IN,
  input  logic                 START,
  input  logic                 RUN_EN,
  input  logic                 ADVANCE_EN,
  input  logic                 GEN_CLEAR,
  output logic [COLS-1:0]      ROW_DATA,
  output logic [IDX_W-1:0]     ROW_IDX,
  output logic                 ROW_VALID,
  input  logic                 ROW_READY,
  output logic                 ROW_LAST,
  output logic [CNT_W-1:0]     LIVE_COUNT,
  output logic [GEN_WIDTH-1:0] FRAME_GEN,
  output logic                 CLK_EN_OUT,
  output logic                 BUSY
);

  reader_state_t        r_state;
  reader_state_t        w_state_next;
  logic [GRID_W-1:0]    r_snap;
  logic [COLS-1:0]      r_row_data;
  logic [IDX_W-1:0]     r_row_idx;
  logic                 r_row_valid;
  logic                 r_row_last;
  logic [CNT_W-1:0]     r_live;
  logic [GEN_WIDTH-1:0] r_frame_gen;
  logic [GEN_WIDTH-1:0] r_gen;
  logic                 r_clk_en;
  logic                 r_busy;

  logic                 w_handshake;
  logic [IDX_W-1:0]     w_idx_next;
  logic [CNT_W-1:0]     w_pop;
  logic [COLS-1:0]      w_first_row;
  logic [COLS-1:0]      w_next_row;

  popcount_tree #(.WIDTH(GRID_W)) u_popcount (
    .i_bits    (STATE_IN),
    .o_count_c (w_pop)
  );

  assign w_handshake = r_row_valid & ROW_READY;
  assign w_idx_next  = r_row_idx + IDX_W'(1);
  // Row 0 comes straight from the input since the snapshot is loaded on the same edge.
  assign w_first_row = COLS'(row_slice(MAX_GRID'(STATE_IN), 0, COLS));
  assign w_next_row  = COLS'(row_slice(MAX_GRID'(r_snap), 32'(w_idx_next), COLS));

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (START || RUN_EN) w_state_next = CAPTURE;
      CAPTURE: w_state_next = SEND;
      SEND:    if (w_handshake && r_row_last) w_state_next = ADVANCE_EN ? ADVANCE : IDLE;
      ADVANCE: w_state_next = SETTLE;
      SETTLE:  w_state_next = RUN_EN ? CAPTURE : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_snap      <= '0;
      r_row_data  <= '0;
      r_row_idx   <= '0;
      r_row_valid <= 1'b0;
      r_row_last  <= 1'b0;
      r_live      <= '0;
      r_frame_gen <= '0;
      r_gen       <= '0;
      r_clk_en    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_busy   <= (w_state_next != IDLE);
      r_clk_en <= (w_state_next == ADVANCE);

      // Clear wins over the post-advance increment.
      if (GEN_CLEAR)               r_gen <= '0;
      else if (r_state == ADVANCE) r_gen <= r_gen + GEN_WIDTH'(1);

      case (r_state)
        CAPTURE: begin
          r_snap      <= STATE_IN;
          r_live      <= w_pop;
          r_frame_gen <= r_gen;
          r_row_idx   <= '0;
          r_row_data  <= w_first_row;
          r_row_valid <= 1'b1;
          r_row_last  <= (ROWS == 1);
        end
        SEND: begin
          if (w_handshake) begin
            if (r_row_last) begin
              r_row_valid <= 1'b0;
              r_row_last  <= 1'b0;
            end else begin
              r_row_idx  <= w_idx_next;
              r_row_data <= w_next_row;
              r_row_last <= (w_idx_next == IDX_W'(ROWS - 1));
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ROW_DATA   = r_row_data;
  assign ROW_IDX    = r_row_idx;
  assign ROW_VALID  = r_row_valid;
  assign ROW_LAST   = r_row_last;
  assign LIVE_COUNT = r_live;
  assign FRAME_GEN  = r_frame_gen;
  assign CLK_EN_OUT = r_clk_en;
  assign BUSY       = r_busy;

endmodule

// File: tb/tb_conway_state_reader.sv
// Bench for conway_state_reader: table frames, random frames, reset abort and free-run stepping.
module tb_conway_state_reader;

  localparam int unsigned ROWS = 8;
  localparam int unsigned COLS = 8;
  localparam int unsigned GW   = 4;
  localparam int unsigned IW   = 3;
  localparam int unsigned CW   = 7;

  logic                 CLK = 1'b0;
  logic                 RESET;
  logic [63:0]          STATE_IN;
  logic                 START, RUN_EN, ADVANCE_EN, GEN_CLEAR, ROW_READY;
  logic [COLS-1:0]      ROW_DATA;
  logic [IW-1:0]        ROW_IDX;
  logic                 ROW_VALID, ROW_LAST, CLK_EN_OUT, BUSY;
  logic [CW-1:0]        LIVE_COUNT;
  logic [GW-1:0]        FRAME_GEN;

  int n_tests = 0;
  int n_fail  = 0;
  int model_gen = 0;

  conway_state_reader #(.ROWS(ROWS), .COLS(COLS), .GEN_WIDTH(GW)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .STATE_IN   (STATE_IN),
    .START      (START),
    .RUN_EN     (RUN_EN),
    .ADVANCE_EN (ADVANCE_EN),
    .GEN_CLEAR  (GEN_CLEAR),
    .ROW_DATA   (ROW_DATA),
    .ROW_IDX    (ROW_IDX),
    .ROW_VALID  (ROW_VALID),
    .ROW_READY  (ROW_READY),
    .ROW_LAST   (ROW_LAST),
    .LIVE_COUNT (LIVE_COUNT),
    .FRAME_GEN  (FRAME_GEN),
    .CLK_EN_OUT (CLK_EN_OUT),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] grid;
    logic        adv;
    int          ready_mode;  // 0 always, 1 toggle, 2 random
    logic        scramble;    // drive all-ones during SEND
    logic        start_mid;   // pulse START while busy
    int          exp_live;
    int          exp_pulses;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [COLS-1:0] row_of(input logic [63:0] grid, input int r);
    logic [63:0] g;
    g = grid >> (r * COLS);
    return g[COLS-1:0];
  endfunction

  task automatic do_reset;
    RESET = 1'b1; START = 1'b0; RUN_EN = 1'b0; ADVANCE_EN = 1'b0;
    GEN_CLEAR = 1'b0; ROW_READY = 1'b0; STATE_IN = '0;
    step; step;
    RESET = 1'b0;
    model_gen = 0;
  endtask

  // One START-initiated frame; beats compared against the grid presented at capture.
  task automatic run_frame(input logic [63:0] grid, input logic adv, input int mode,
                           input logic scramble, input logic start_mid,
                           input int exp_live, input int exp_pulses);
    int beats, cycles, pulses, extra;
    logic rdy, stalled;
    logic [COLS-1:0] prev_data;
    logic [IW-1:0]   prev_idx;
    check("idle_before_start", 64'(BUSY), 64'(0));
    STATE_IN = grid; ADVANCE_EN = adv; ROW_READY = 1'b0; START = 1'b1;
    step;
    START = 1'b0;
    check("capture_busy", 64'(BUSY), 64'(1));
    check("capture_no_valid", 64'(ROW_VALID), 64'(0));
    step;
    check("first_valid", 64'(ROW_VALID), 64'(1));
    check("live_count", 64'(LIVE_COUNT), 64'(exp_live));
    check("frame_gen", 64'(FRAME_GEN), 64'(model_gen));
    beats = 0; cycles = 0; pulses = 0; stalled = 1'b0;
    prev_data = '0; prev_idx = '0;
    while (beats < int'(ROWS) && cycles < 200) begin
      STATE_IN = scramble ? '1 : {$urandom, $urandom};
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cycles % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ROW_READY  = rdy;
      ADVANCE_EN = (rdy && beats == int'(ROWS) - 1) ? adv : 1'($urandom_range(0, 1));
      START      = start_mid && (cycles == 2);
      check("valid_in_frame", 64'(ROW_VALID), 64'(1));
      if (stalled) begin
        check("stall_hold_data", 64'(ROW_DATA), 64'(prev_data));
        check("stall_hold_idx", 64'(ROW_IDX), 64'(prev_idx));
      end
      if (rdy) begin
        check("row_idx", 64'(ROW_IDX), 64'(beats));
        check("row_data", 64'(ROW_DATA), 64'(row_of(grid, beats)));
        check("row_last", 64'(ROW_LAST), 64'(beats == int'(ROWS) - 1));
        beats++;
      end
      if (CLK_EN_OUT) pulses++;
      stalled = !rdy; prev_data = ROW_DATA; prev_idx = ROW_IDX;
      step;
      cycles++;
    end
    check("frame_complete", 64'(beats), 64'(ROWS));
    ROW_READY = 1'b0; START = 1'b0; ADVANCE_EN = 1'b0;
    check("valid_drop", 64'(ROW_VALID), 64'(0));
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      if (CLK_EN_OUT) pulses++;
      if (ROW_VALID) extra++;
      step;
    end
    check("adv_pulses", 64'(pulses), 64'(exp_pulses));
    check("no_extra_frame", 64'(extra), 64'(0));
    check("idle_after", 64'(BUSY), 64'(0));
    model_gen = (model_gen + exp_pulses) % (1 << GW);
  endtask

  initial begin
    vec_t vecs[5];
    logic [63:0] g;
    logic a;
    int bad, k;

    vecs[0] = '{64'h0000_0000_0000_00FF, 1'b0, 0, 1'b0, 1'b0, 8, 0};
    vecs[1] = '{64'h0000_0000_0000_00FF, 1'b0, 1, 1'b1, 1'b0, 8, 0};
    vecs[2] = '{64'h8000_0000_0000_0001, 1'b1, 0, 1'b0, 1'b0, 2, 1};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2, 1'b0, 1'b1, 64, 0};
    vecs[4] = '{64'h0123_4567_89AB_CDEF, 1'b1, 2, 1'b0, 1'b0, 32, 1};

    do_reset;
    check("rst_row_data", 64'(ROW_DATA), 64'(0));
    check("rst_row_idx", 64'(ROW_IDX), 64'(0));
    check("rst_row_valid", 64'(ROW_VALID), 64'(0));
    check("rst_row_last", 64'(ROW_LAST), 64'(0));
    check("rst_live", 64'(LIVE_COUNT), 64'(0));
    check("rst_frame_gen", 64'(FRAME_GEN), 64'(0));
    check("rst_clk_en", 64'(CLK_EN_OUT), 64'(0));
    check("rst_busy", 64'(BUSY), 64'(0));

    foreach (vecs[i])
      run_frame(vecs[i].grid, vecs[i].adv, vecs[i].ready_mode, vecs[i].scramble,
                vecs[i].start_mid, vecs[i].exp_live, vecs[i].exp_pulses);

    for (int i = 0; i < 12; i++) begin
      g = {$urandom, $urandom};
      a = 1'($urandom_range(0, 1));
      run_frame(g, a, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0,
                $countones(g), int'(a));
    end

    // Reset while beat 3 is on the bus.
    STATE_IN = {$urandom, $urandom}; ADVANCE_EN = 1'b1; START = 1'b1;
    step;
    START = 1'b0; ROW_READY = 1'b1;
    step;
    k = 0;
    while (ROW_IDX != IW'(3) && k < 20) begin
      step;
      k++;
    end
    check("reach_beat3", 64'(ROW_IDX), 64'(3));
    RESET = 1'b1;
    step;
    RESET = 1'b0; ROW_READY = 1'b0; ADVANCE_EN = 1'b0;
    check("abort_valid", 64'(ROW_VALID), 64'(0));
    check("abort_busy", 64'(BUSY), 64'(0));
    check("abort_clk_en", 64'(CLK_EN_OUT), 64'(0));
    check("abort_gen", 64'(FRAME_GEN), 64'(0));
    model_gen = 0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (CLK_EN_OUT || BUSY) bad++;
      step;
    end
    check("abort_quiet", 64'(bad), 64'(0));
    g = 64'h00FF_0000_F0F0_0001;
    run_frame(g, 1'b0, 0, 1'b0, 1'b0, $countones(g), 0);

    // Free-run: 11-cycle period, generation sequence with wrap, clear on an advance, stop.
    begin
      int cyc, last_pulse, npulses, f, eg, nvalid;
      do_reset;
      RUN_EN = 1'b1; ADVANCE_EN = 1'b1; ROW_READY = 1'b1;
      step;
      cyc = 0; last_pulse = -1; npulses = 0; f = 0; eg = 0; nvalid = 0;
      while (cyc < 400) begin
        GEN_CLEAR = 1'b0;
        STATE_IN  = {$urandom, $urandom};
        if (CLK_EN_OUT) begin
          if (last_pulse >= 0) check("run_period", 64'(cyc - last_pulse), 64'(11));
          last_pulse = cyc;
          npulses++;
          if (f == 18) begin
            GEN_CLEAR = 1'b1;
            eg = 0;
          end else begin
            eg = (eg + 1) % (1 << GW);
          end
        end
        if (ROW_VALID) nvalid++;
        if (ROW_VALID && ROW_IDX == '0) begin
          f++;
          check("run_frame_gen", 64'(FRAME_GEN), 64'(eg));
          if (f == 19) RUN_EN = 1'b0;
        end
        if (f == 19 && !BUSY) break;
        step;
        cyc++;
      end
      GEN_CLEAR = 1'b0; RUN_EN = 1'b0; ADVANCE_EN = 1'b0; ROW_READY = 1'b0;
      check("run_stopped", 64'(BUSY), 64'(0));
      check("run_pulses", 64'(npulses), 64'(19));
      check("run_beats", 64'(nvalid), 64'(19 * ROWS));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
